noc_response_axi_burst: RTL and testbench

NOC_RESPONSE_AXI_BURST -- requirements
Module: noc_response_axi_burst

---
 rtl/noc_axi_resp_pkg.sv | 51 +++++
 rtl/noc_resp_fifo.sv | 55 +++++
 rtl/noc_response_axi_burst.sv | 265 ++++++++++++++++++++++++++
 tb/tb_noc_response_axi_burst.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_axi_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_axi_resp_pkg                                                           |
// | Shared types, header field layout and helpers for noc_response_axi_burst.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif

package noc_axi_resp_pkg;

    // Header flit: [7:0] message type, [8 +: MSG_LENGTH_WIDTH] payload flit count
    localparam int          c_msg_type_width = 8;
    localparam int          c_msg_length_lsb = 8;
    localparam logic [7:0]  c_msg_data_ack   = 8'h03;
    localparam int          c_txn_id_width   = 8;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [c_txn_id_width-1:0] id;
        logic                      is_store;
        logic                      last;
        logic                      size16;
        logic                      word_sel;
    } txn_info_t;

    typedef enum logic [1:0] {
        HEADER    = 2'd0,
        READ_DATA = 2'd1,
        STORE_ACK = 2'd2,
        DROP      = 2'd3
    } resp_state_t;

    function automatic logic [63:0] byte_swap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_resp_fifo                                                              |
// | Synchronous first-word-fall-through FIFO, power-of-2 depth.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module noc_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                   (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign dout  = r_mem[r_rd_ptr[c_addr_w-1:0]];

    // A push into a full FIFO is legal only when the head leaves on the same edge
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/noc_response_axi_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_response_axi_burst                                                     |
// | Converts NoC response flits into AXI R beats / B responses.                |
// | Optional macro NOC_RESP_SLVERR_EN: non-DATA_ACK headers answer SLVERR.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module noc_response_axi_burst
    import noc_axi_resp_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       noc_valid_in,
    input  logic [`NOC_DATA_WIDTH-1:0] noc_data_in,
    output logic                       noc_ready_out,
    input  logic                       txn_info_valid,
    output logic                       txn_info_ready,
    input  txn_info_t                  txn_info,
    output logic [AXI_ID_WIDTH-1:0]    m_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]  m_axi_rdata,
    output logic [1:0]                 m_axi_rresp,
    output logic                       m_axi_rlast,
    output logic                       m_axi_rvalid,
    input  logic                       m_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]    m_axi_bid,
    output logic [1:0]                 m_axi_bresp,
    output logic                       m_axi_bvalid,
    input  logic                       m_axi_bready
);

    localparam int c_len_w  = `MSG_LENGTH_WIDTH;
    localparam int c_info_w = $bits(txn_info_t);
    localparam int c_r_w    = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3;
    localparam int c_b_w    = AXI_ID_WIDTH + 2;
`ifdef NOC_RESP_SLVERR_EN
    localparam bit c_slverr_en = 1'b1;
`else
    localparam bit c_slverr_en = 1'b0;
`endif

    resp_state_t         r_state;
    logic [c_len_w-1:0]  r_len;
    logic [c_len_w-1:0]  r_count;
    logic                r_init;

    logic [c_info_w-1:0] w_info_dout;
    txn_info_t           w_head;
    logic                w_info_full, w_info_empty, w_info_pop;
    logic [c_r_w-1:0]    w_r_din, w_r_dout;
    logic                w_r_push, w_r_full, w_r_empty;
    logic [c_b_w-1:0]    w_b_din, w_b_dout;
    logic                w_b_push, w_b_full, w_b_empty;

    logic                      w_noc_ready, w_flit_acc, w_err_emit;
    logic [7:0]                w_hdr_type;
    logic [c_len_w-1:0]        w_hdr_len, w_len_m1, w_last_kept_idx;
    logic                      w_hdr_ack, w_hdr_zero, w_zero_b, w_zero_r;
    logic                      w_is_final, w_keep, w_is_last_kept;
    logic [63:0]               w_swapped;
    logic [AXI_DATA_WIDTH-1:0] w_beat_data, w_r_data;
    logic                      w_beat_take, w_beat_last, w_r_last;
    logic [1:0]                w_r_resp, w_b_resp;
    logic                      w_unused_id;

    assign w_head      = txn_info_t'(w_info_dout);
    assign w_unused_id = &{1'b0, w_head.id};

    assign w_hdr_type = noc_data_in[c_msg_type_width-1:0];
    assign w_hdr_len  = noc_data_in[c_msg_length_lsb +: c_len_w];
    assign w_hdr_ack  = (w_hdr_type == c_msg_data_ack);
    assign w_hdr_zero = (w_hdr_len == '0);
    assign w_zero_b   = w_head.is_store && w_head.last && (w_hdr_ack || c_slverr_en);
    assign w_zero_r   = c_slverr_en && !w_hdr_ack && !w_head.is_store;

    assign w_len_m1   = r_len - c_len_w'(1);
    assign w_is_final = (r_count == w_len_m1);
    assign w_swapped  = byte_swap64(noc_data_in[63:0]);

    assign w_keep          = w_head.size16 ? (r_count < c_len_w'(2))
                                           : (r_count == c_len_w'(w_head.word_sel));
    assign w_last_kept_idx = w_head.size16 ? ((r_len >= c_len_w'(2)) ? c_len_w'(1) : '0)
                                           : c_len_w'(w_head.word_sel);
    assign w_is_last_kept  = w_keep && (r_count == w_last_kept_idx);

    if (AXI_DATA_WIDTH == 128) begin : g_pack_128
        logic [127:0] r_acc;
        logic         w_single;
        logic         w_upper;

        // A lone kept flit lands in the half named by word_sel; pairs go low then high
        assign w_single    = !w_head.size16 || (r_len < c_len_w'(2));
        assign w_upper     = w_single ? w_head.word_sel : r_count[0];
        assign w_beat_take = w_is_last_kept;
        assign w_beat_last = w_head.last;

        always_comb begin
            w_beat_data = r_acc;
            if (w_upper) w_beat_data[127:64] = w_swapped;
            else         w_beat_data[63:0]   = w_swapped;
        end

        always_ff @(posedge clk) begin
            if (rst || (r_state == HEADER)) begin
                r_acc <= '0;
            end else if ((r_state == READ_DATA) && w_flit_acc && w_keep) begin
                r_acc <= w_beat_take ? '0 : w_beat_data;
            end
        end
    end else begin : g_pack_64
        assign w_beat_data = w_swapped;
        assign w_beat_take = w_keep;
        assign w_beat_last = w_head.last && w_is_last_kept;
    end

    always_comb begin
        w_noc_ready = 1'b0;
        case (r_state)
            HEADER:    w_noc_ready = !w_info_empty &&
                                     !(w_hdr_zero && w_zero_b && w_b_full) &&
                                     !(w_hdr_zero && w_zero_r && w_r_full);
            READ_DATA: w_noc_ready = !w_r_full;
            STORE_ACK: w_noc_ready = !w_is_final || !w_b_full;
            DROP: begin
                if (c_slverr_en && w_is_final)
                    w_noc_ready = w_head.is_store ? (!w_head.last || !w_b_full) : !w_r_full;
                else
                    w_noc_ready = 1'b1;
            end
            default:   w_noc_ready = 1'b0;
        endcase
    end

    assign noc_ready_out  = w_noc_ready && !r_init && !rst;
    assign w_flit_acc     = noc_valid_in && noc_ready_out;
    assign txn_info_ready = !w_info_full && !r_init && !rst;

    always_comb begin
        w_r_push   = 1'b0;
        w_r_data   = w_beat_data;
        w_r_resp   = RESP_OKAY;
        w_r_last   = w_beat_last;
        w_b_push   = 1'b0;
        w_b_resp   = RESP_OKAY;
        w_info_pop = 1'b0;
        w_err_emit = 1'b0;
        if (w_flit_acc) begin
            case (r_state)
                HEADER: begin
                    if (w_hdr_zero && w_hdr_ack) begin
                        w_info_pop = 1'b1;
                        w_b_push   = w_head.is_store && w_head.last;
                    end else if (w_hdr_zero && c_slverr_en) begin
                        w_info_pop = 1'b1;
                        w_err_emit = 1'b1;
                    end
                end
                READ_DATA: begin
                    w_r_push   = w_beat_take;
                    w_info_pop = w_is_final;
                end
                STORE_ACK: begin
                    w_info_pop = w_is_final;
                    w_b_push   = w_is_final && w_head.last;
                end
                DROP: begin
                    if (c_slverr_en && w_is_final) begin
                        w_info_pop = 1'b1;
                        w_err_emit = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (w_err_emit) begin
            if (w_head.is_store) begin
                w_b_push = w_head.last;
                w_b_resp = RESP_SLVERR;
            end else begin
                w_r_push = 1'b1;
                w_r_data = '0;
                w_r_resp = RESP_SLVERR;
                w_r_last = w_head.last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HEADER;
            r_len   <= '0;
            r_count <= '0;
            r_init  <= 1'b1;
        end else begin
            r_init <= 1'b0;
            if (w_flit_acc) begin
                if (r_state == HEADER) begin
                    r_len   <= w_hdr_len;
                    r_count <= '0;
                    if (!w_hdr_zero) begin
                        if (!w_hdr_ack)           r_state <= DROP;
                        else if (w_head.is_store) r_state <= STORE_ACK;
                        else                      r_state <= READ_DATA;
                    end
                end else begin
                    r_count <= r_count + c_len_w'(1);
                    if (w_is_final) r_state <= HEADER;
                end
            end
        end
    end

    assign w_r_din = {w_head.id[AXI_ID_WIDTH-1:0], w_r_data, w_r_resp, w_r_last};
    assign w_b_din = {w_head.id[AXI_ID_WIDTH-1:0], w_b_resp};

    noc_resp_fifo #(.WIDTH(c_info_w), .DEPTH(FIFO_DEPTH)) u_info_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (txn_info_valid && txn_info_ready),
        .din   (txn_info),
        .pop   (w_info_pop),
        .dout  (w_info_dout),
        .full  (w_info_full),
        .empty (w_info_empty)
    );

    noc_resp_fifo #(.WIDTH(c_r_w), .DEPTH(FIFO_DEPTH)) u_r_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_r_push),
        .din   (w_r_din),
        .pop   (m_axi_rvalid && m_axi_rready),
        .dout  (w_r_dout),
        .full  (w_r_full),
        .empty (w_r_empty)
    );

    noc_resp_fifo #(.WIDTH(c_b_w), .DEPTH(FIFO_DEPTH)) u_b_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_b_push),
        .din   (w_b_din),
        .pop   (m_axi_bvalid && m_axi_bready),
        .dout  (w_b_dout),
        .full  (w_b_full),
        .empty (w_b_empty)
    );

    assign m_axi_rvalid = !w_r_empty && !r_init;
    assign m_axi_rid    = m_axi_rvalid ? w_r_dout[c_r_w-1 -: AXI_ID_WIDTH] : '0;
    assign m_axi_rdata  = m_axi_rvalid ? w_r_dout[AXI_DATA_WIDTH+2:3] : '0;
    assign m_axi_rresp  = m_axi_rvalid ? w_r_dout[2:1] : 2'b00;
    assign m_axi_rlast  = m_axi_rvalid && w_r_dout[0];

    assign m_axi_bvalid = !w_b_empty && !r_init;
    assign m_axi_bid    = m_axi_bvalid ? w_b_dout[c_b_w-1 -: AXI_ID_WIDTH] : '0;
    assign m_axi_bresp  = m_axi_bvalid ? w_b_dout[1:0] : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_noc_response_axi_burst.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_noc_response_axi_burst                                                  |
// | Directed bench for noc_response_axi_burst (64- and 128-bit instances).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_noc_response_axi_burst;
    import noc_axi_resp_pkg::*;

    localparam logic [63:0] F0 = 64'h0102030405060708;
    localparam logic [63:0] F1 = 64'h1112131415161718;
    localparam logic [63:0] F2 = 64'h2122232425262728;
    localparam logic [63:0] S0 = 64'h0807060504030201;
    localparam logic [63:0] S1 = 64'h1817161514131211;

    typedef struct {
        logic         w128;
        logic [7:0]   id;
        logic         st, last, s16, ws;
        logic [7:0]   len;
        int           nr;
        logic [127:0] e0;
        logic         l0;
        logic [127:0] e1;
        logic         l1;
        int           nb;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, noc_valid, info_valid, rready, bready, sel128;
    logic [63:0] noc_data;
    txn_info_t   info;

    logic         a_noc_ready, a_info_ready, a_rlast, a_rvalid, a_bvalid;
    logic [3:0]   a_rid, a_bid;
    logic [63:0]  a_rdata;
    logic [1:0]   a_rresp, a_bresp;
    logic         b_noc_ready, b_info_ready, b_rlast, b_rvalid, b_bvalid;
    logic [3:0]   b_rid, b_bid;
    logic [127:0] b_rdata;
    logic [1:0]   b_rresp, b_bresp;

    noc_response_axi_burst #(.AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .noc_valid_in(noc_valid && !sel128), .noc_data_in(noc_data), .noc_ready_out(a_noc_ready),
        .txn_info_valid(info_valid && !sel128), .txn_info_ready(a_info_ready), .txn_info(info),
        .m_axi_rid(a_rid), .m_axi_rdata(a_rdata), .m_axi_rresp(a_rresp), .m_axi_rlast(a_rlast),
        .m_axi_rvalid(a_rvalid), .m_axi_rready(rready),
        .m_axi_bid(a_bid), .m_axi_bresp(a_bresp), .m_axi_bvalid(a_bvalid), .m_axi_bready(bready)
    );

    noc_response_axi_burst #(.AXI_DATA_WIDTH(128), .AXI_ID_WIDTH(4), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst),
        .noc_valid_in(noc_valid && sel128), .noc_data_in(noc_data), .noc_ready_out(b_noc_ready),
        .txn_info_valid(info_valid && sel128), .txn_info_ready(b_info_ready), .txn_info(info),
        .m_axi_rid(b_rid), .m_axi_rdata(b_rdata), .m_axi_rresp(b_rresp), .m_axi_rlast(b_rlast),
        .m_axi_rvalid(b_rvalid), .m_axi_rready(rready),
        .m_axi_bid(b_bid), .m_axi_bresp(b_bresp), .m_axi_bvalid(b_bvalid), .m_axi_bready(bready)
    );

    logic         m_noc_ready, m_info_ready, m_rvalid, m_rlast, m_bvalid;
    logic [3:0]   m_rid, m_bid;
    logic [127:0] m_rdata;
    logic [1:0]   m_rresp, m_bresp;

    assign m_noc_ready  = sel128 ? b_noc_ready  : a_noc_ready;
    assign m_info_ready = sel128 ? b_info_ready : a_info_ready;
    assign m_rvalid     = sel128 ? b_rvalid : a_rvalid;
    assign m_rlast      = sel128 ? b_rlast  : a_rlast;
    assign m_rid        = sel128 ? b_rid    : a_rid;
    assign m_rdata      = sel128 ? b_rdata  : {64'h0, a_rdata};
    assign m_rresp      = sel128 ? b_rresp  : a_rresp;
    assign m_bvalid     = sel128 ? b_bvalid : a_bvalid;
    assign m_bid        = sel128 ? b_bid    : a_bid;
    assign m_bresp      = sel128 ? b_bresp  : a_bresp;

    logic [127:0] rq_data[$];
    logic [3:0]   rq_id[$];
    logic         rq_last[$];
    logic [1:0]   rq_resp[$];
    logic [3:0]   bq_id[$];
    logic [1:0]   bq_resp[$];
    int           zero_viol = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_rvalid && rready) begin
                rq_data.push_back(m_rdata);
                rq_id.push_back(m_rid);
                rq_last.push_back(m_rlast);
                rq_resp.push_back(m_rresp);
            end
            if (m_bvalid && bready) begin
                bq_id.push_back(m_bid);
                bq_resp.push_back(m_bresp);
            end
            if (!a_rvalid && (a_rdata != 0 || a_rid != 0 || a_rlast || a_rresp != 0)) zero_viol++;
            if (!b_rvalid && (b_rdata != 0 || b_rid != 0 || b_rlast || b_rresp != 0)) zero_viol++;
            if (!a_bvalid && (a_bid != 0 || a_bresp != 0)) zero_viol++;
            if (!b_bvalid && (b_bid != 0 || b_bresp != 0)) zero_viol++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        rq_data.delete(); rq_id.delete(); rq_last.delete(); rq_resp.delete();
        bq_id.delete(); bq_resp.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input txn_info_t d);
        bit ok = 1'b0;
        info       = d;
        info_valid = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (m_info_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("desc_timeout", 0, 1);
        @(posedge clk); #1;
        info_valid = 1'b0;
    endtask

    task automatic send_flit(input logic [63:0] d);
        bit ok = 1'b0;
        noc_data  = d;
        noc_valid = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (m_noc_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("flit_timeout", 0, 1);
        @(posedge clk); #1;
        noc_valid = 1'b0;
    endtask

    function automatic txn_info_t mkd(input logic [7:0] id, input logic st, input logic last,
                                      input logic s16, input logic ws);
        txn_info_t d;
        d.id = id; d.is_store = st; d.last = last; d.size16 = s16; d.word_sel = ws;
        return d;
    endfunction

    function automatic vec_t mk(input logic w, input logic [7:0] id, input logic st,
                                input logic last, input logic s16, input logic ws,
                                input logic [7:0] len, input int nr,
                                input logic [127:0] e0, input logic l0,
                                input logic [127:0] e1, input logic l1, input int nb);
        vec_t v;
        v.w128 = w; v.id = id; v.st = st; v.last = last; v.s16 = s16; v.ws = ws;
        v.len = len; v.nr = nr; v.e0 = e0; v.l0 = l0; v.e1 = e1; v.l1 = l1; v.nb = nb;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [127:0] e;
        logic         l;
        sel128 = v.w128;
        clear_q();
        push_desc(mkd(v.id, v.st, v.last, v.s16, v.ws));
        send_flit({48'h0, v.len, c_msg_data_ack});
        for (int k = 0; k < int'(v.len); k++) send_flit((k == 0) ? F0 : (k == 1) ? F1 : F2);
        tick(6);
        chk($sformatf("v%0d_rbeats", idx), rq_data.size(), v.nr);
        for (int i = 0; i < v.nr && i < rq_data.size(); i++) begin
            e = (i == 0) ? v.e0 : v.e1;
            l = (i == 0) ? v.l0 : v.l1;
            chk($sformatf("v%0d_rdata%0d", idx, i), rq_data[i], e);
            chk($sformatf("v%0d_rlast%0d", idx, i), rq_last[i], l);
            chk($sformatf("v%0d_rid%0d", idx, i), rq_id[i], v.id[3:0]);
            chk($sformatf("v%0d_rresp%0d", idx, i), rq_resp[i], 2'b00);
        end
        chk($sformatf("v%0d_bresps", idx), bq_id.size(), v.nb);
        if (v.nb > 0 && bq_id.size() > 0) begin
            chk($sformatf("v%0d_bid", idx), bq_id[0], v.id[3:0]);
            chk($sformatf("v%0d_bresp", idx), bq_resp[0], 2'b00);
        end
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = mk(0, 8'h3, 0, 1, 1, 0, 8'd2, 2, S0, 0, S1, 1, 0);
        vecs[1]  = mk(0, 8'h5, 1, 1, 0, 0, 8'd1, 0, 0, 0, 0, 0, 1);
        vecs[2]  = mk(0, 8'h5, 1, 0, 0, 0, 8'd1, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 8'h2, 0, 1, 0, 1, 8'd2, 1, S1, 1, 0, 0, 0);
        vecs[4]  = mk(0, 8'h1, 0, 0, 0, 0, 8'd3, 1, S0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 8'h6, 0, 1, 1, 0, 8'd3, 2, S0, 0, S1, 1, 0);
        vecs[6]  = mk(1, 8'h3, 0, 1, 1, 0, 8'd2, 1, {S1, S0}, 1, 0, 0, 0);
        vecs[7]  = mk(1, 8'h2, 0, 1, 0, 1, 8'd2, 1, {S1, 64'h0}, 1, 0, 0, 0);
        vecs[8]  = mk(1, 8'h9, 0, 0, 0, 0, 8'd2, 1, {64'h0, S0}, 0, 0, 0, 0);
        vecs[9]  = mk(1, 8'h4, 0, 1, 1, 1, 8'd1, 1, {S0, 64'h0}, 1, 0, 0, 0);
        vecs[10] = mk(0, 8'hA, 1, 1, 0, 0, 8'd3, 0, 0, 0, 0, 0, 1);

        rst = 1'b1; noc_valid = 1'b0; info_valid = 1'b0; noc_data = '0;
        info = '0; rready = 1'b1; bready = 1'b1; sel128 = 1'b0;

        // Reset: everything quiet during reset and the cycle after
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_noc_ready", a_noc_ready, 0);
        chk("rst_info_ready", a_info_ready, 0);
        chk("rst_rvalid", a_rvalid, 0);
        chk("rst_bvalid", a_bvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_info_ready", a_info_ready, 0);
        chk("post_rst_noc_ready", a_noc_ready, 0);
        @(negedge clk);
        chk("idle_info_ready", a_info_ready, 1);
        tick(1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
        sel128 = 1'b0;

        // Backpressure: ten load flits with R stalled; FIFO holds eight beats
        clear_q();
        rready = 1'b0;
        for (int t = 0; t < 5; t++) push_desc(mkd(8'(t + 1), 0, 1, 1, 0));
        for (int t = 0; t < 4; t++) begin
            send_flit({48'h0, 8'd2, c_msg_data_ack});
            send_flit({8'(2*t), 48'h0, 8'(8'hA0 + 2*t)});
            send_flit({8'(2*t+1), 48'h0, 8'(8'hA0 + 2*t + 1)});
        end
        send_flit({48'h0, 8'd2, c_msg_data_ack});
        noc_data  = {8'd8, 48'h0, 8'hA8};
        noc_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("bp_ready_low", a_noc_ready, 0);
        chk("bp_no_drain", rq_data.size(), 0);
        rready = 1'b1;
        send_flit({8'd8, 48'h0, 8'hA8});
        send_flit({8'd9, 48'h0, 8'hA9});
        tick(20);
        chk("bp_count", rq_data.size(), 10);
        for (int i = 0; i < 10 && i < rq_data.size(); i++) begin
            chk($sformatf("bp_data%0d", i), rq_data[i], {64'h0, 8'(8'hA0 + i), 48'h0, 8'(i)});
            chk($sformatf("bp_id%0d", i), rq_id[i], 4'(i / 2 + 1));
            chk($sformatf("bp_last%0d", i), rq_last[i], (i % 2) == 1);
        end

        // Non-DATA_ACK header on a load descriptor
        clear_q();
        push_desc(mkd(8'h7, 0, 1, 1, 0));
        send_flit({48'h0, 8'd2, 8'h05});
        send_flit(F0);
        send_flit(F1);
        tick(6);
`ifdef NOC_RESP_SLVERR_EN
        chk("err_beats", rq_data.size(), 1);
        if (rq_data.size() > 0) begin
            chk("err_rresp", rq_resp[0], 2'b10);
            chk("err_rdata", rq_data[0], 0);
            chk("err_rlast", rq_last[0], 1);
            chk("err_rid", rq_id[0], 4'h7);
        end
`else
        chk("drop_no_beat", rq_data.size(), 0);
        send_flit({48'h0, 8'd1, c_msg_data_ack});
        send_flit(F0);
        tick(6);
        chk("retain_beats", rq_data.size(), 1);
        if (rq_data.size() > 0) begin
            chk("retain_rid", rq_id[0], 4'h7);
            chk("retain_rdata", rq_data[0], {64'h0, S0});
            chk("retain_rlast", rq_last[0], 1);
        end
`endif

        // Reset in the middle of a READ_DATA burst
        clear_q();
        rready = 1'b0;
        push_desc(mkd(8'h3, 0, 1, 1, 0));
        send_flit({48'h0, 8'd2, c_msg_data_ack});
        send_flit(F0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rvalid", a_rvalid, 0);
        chk("mid_rst_bvalid", a_bvalid, 0);
        chk("mid_rst_state", dut_a.r_state == HEADER, 1);
        chk("mid_rst_noc_ready", a_noc_ready, 0);
        rready = 1'b1;
        tick(4);
        chk("mid_rst_discard", rq_data.size(), 0);
        push_desc(mkd(8'h3, 0, 1, 1, 0));
        send_flit({48'h0, 8'd2, c_msg_data_ack});
        send_flit(F0);
        @(negedge clk);
        chk("latency_rvalid", a_rvalid, 1);
        @(posedge clk); #1;
        send_flit(F1);
        tick(6);
        chk("after_rst_beats", rq_data.size(), 2);
        if (rq_data.size() == 2) begin
            chk("after_rst_d0", rq_data[0], {64'h0, S0});
            chk("after_rst_d1", rq_data[1], {64'h0, S1});
            chk("after_rst_l1", rq_last[1], 1);
        end

        chk("zero_when_idle", zero_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
